// File: rtl/muldiv_ctrl_pkg.sv
// Shared funct codes and small helpers for the multiply/divide controller.
package muldiv_ctrl_pkg;

  typedef logic [5:0] funct_t;

  localparam funct_t FUNCT_MFHI  = 6'h10;
  localparam funct_t FUNCT_MTHI  = 6'h11;
  localparam funct_t FUNCT_MFLO  = 6'h12;
  localparam funct_t FUNCT_MTLO  = 6'h13;
  localparam funct_t FUNCT_MULT  = 6'h18;
  localparam funct_t FUNCT_MULTU = 6'h19;
  localparam funct_t FUNCT_DIV   = 6'h1a;
  localparam funct_t FUNCT_DIVU  = 6'h1b;

  // True for the four iterative operations.
  function automatic logic is_muldiv(funct_t f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

  // Magnitude of v when neg is set (two's complement), else v unchanged.
  function automatic logic [31:0] mag32(logic [31:0] v, logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle iterative datapath: shift-add multiply and restoring
// divide share one 64-bit accumulator. o_next is the post-step value so the
// controller can commit the final step on the same edge it is taken.
module muldiv_iter
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_step,
  input  logic        i_div,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_next
);

  logic [63:0] r_acc;
  logic [31:0] r_b;
  logic [32:0] w_sum;
  logic [32:0] w_trial;
  logic [32:0] w_diff;
  logic [63:0] w_next;

  // Single step: multiply adds b into the upper half when the current
  // multiplier LSB is set, then shifts right; divide shifts the partial
  // remainder left and keeps the trial subtraction when it does not borrow.
  always_comb begin
    w_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    w_trial = r_acc[63:31];
    w_diff  = w_trial - {1'b0, r_b};
    if (i_div)
      w_next = w_diff[32] ? {w_trial[31:0], r_acc[30:0], 1'b0}
                          : {w_diff[31:0],  r_acc[30:0], 1'b1};
    else
      w_next = {w_sum, r_acc[31:1]};
  end

  // Accumulator: load {0, a} at start, advance one step per iteration cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_b   <= '0;
    end else if (i_load) begin
      r_acc <= {32'd0, i_a};
      r_b   <= i_b;
    end else if (i_step) begin
      r_acc <= w_next;
    end
  end

  assign o_next = w_next;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide controller: owns HI/LO, sequences 32-step
// MULT/MULTU/DIV/DIVU, stalls the pipe while iterating, services MTHI/MTLO.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic [5:0]  funct,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  r_state, w_next_state;
  logic [4:0]  r_count;
  logic        r_sa, r_sb;
  logic [31:0] r_hi, r_lo;

  logic        w_start, w_is_div, w_signed, w_div0, w_sa, w_sb;
  logic        w_iter, w_last, w_commit, w_idle_wr;
  logic [63:0] w_res, w_prod;
  logic [31:0] w_quo, w_rem;

  assign w_is_div  = funct[1];
  assign w_signed  = ~funct[0];
  assign w_div0    = w_is_div & (operand_b == 32'd0);
  assign w_sa      = w_signed & operand_a[31];
  assign w_sb      = w_signed & operand_b[31];
  assign w_start   = en & ~flush & (r_state == S_IDLE) & is_muldiv(funct);
  assign w_idle_wr = en & ~flush & (r_state == S_IDLE);
  assign w_iter    = (r_state == S_MUL) | (r_state == S_DIV);
  assign w_last    = w_iter & (r_count == 5'd31);
  assign w_commit  = w_last & ~flush;

  // Sign fix-up on the final-step value; a wrapped negation is the result.
  assign w_prod = (r_sa ^ r_sb) ? (~w_res + 64'd1) : w_res;
  assign w_quo  = (r_sa ^ r_sb) ? (~w_res[31:0] + 32'd1) : w_res[31:0];
  assign w_rem  = r_sa ? (~w_res[63:32] + 32'd1) : w_res[63:32];

  muldiv_iter u_iter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_start & ~w_div0),
    .i_step (w_iter & ~flush),
    .i_div  (r_state == S_DIV),
    .i_a    (mag32(operand_a, w_sa)),
    .i_b    (mag32(operand_b, w_sb)),
    .o_next (w_res)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next state: flush wins from anywhere; DONE always falls back to IDLE.
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start)
                   w_next_state = w_div0 ? S_DONE : (w_is_div ? S_DIV : S_MUL);
        S_MUL,
        S_DIV:   if (w_last) w_next_state = S_DONE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Outputs: stall covers the start cycle and every iteration cycle.
  always_comb begin
    stall_req = ~rst & (w_start | w_iter);
    busy      = (r_state != S_IDLE);
  end

  // Operation context: sign flags and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_count <= '0;
    end else if (w_start) begin
      r_sa    <= w_sa;
      r_sb    <= w_sb;
      r_count <= '0;
    end else if (w_iter) begin
      r_count <= r_count + 5'd1;
    end
  end

  // HI/LO: divide-by-zero result, final commit, or MTHI/MTLO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_start && w_div0) begin
      r_hi <= operand_a;
      r_lo <= 32'hFFFF_FFFF;
    end else if (w_commit) begin
      if (r_state == S_MUL) begin
        r_hi <= w_prod[63:32];
        r_lo <= w_prod[31:0];
      end else begin
        r_hi <= w_rem;
        r_lo <= w_quo;
      end
    end else if (w_idle_wr) begin
      if (funct == FUNCT_MTHI) r_hi <= operand_a;
      if (funct == FUNCT_MTLO) r_lo <= operand_a;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed table, random ops against an
// arithmetic reference model, and hand-written flush/reset/MTHI sequences.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, flush;
  logic [5:0]  funct;
  logic [31:0] operand_a, operand_b;
  logic        stall_req, busy;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a, b, hi, lo;
    int          stalls;
  } vec_t;

  vec_t tv[$];

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .funct(funct),
    .operand_a(operand_a), .operand_b(operand_b),
    .stall_req(stall_req), .hi(hi), .lo(lo), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, MIPS divide-by-zero convention.
  function automatic void model(input logic [5:0] f, input logic [31:0] a, b,
                                output logic [31:0] h, output logic [31:0] l);
    longint x, y, p, q, r;
    logic [63:0] u;
    h = 0; l = 0;
    if (f == FUNCT_MULTU) begin
      u = {32'd0, a} * {32'd0, b};
      h = u[63:32]; l = u[31:0];
    end else if (f == FUNCT_MULT) begin
      x = longint'($signed(a)); y = longint'($signed(b));
      p = x * y;
      h = p[63:32]; l = p[31:0];
    end else if (b == 32'd0) begin
      h = a; l = 32'hFFFF_FFFF;
    end else if (f == FUNCT_DIVU) begin
      l = a / b; h = a % b;
    end else begin
      x = longint'($signed(a)); y = longint'($signed(b));
      q = x / y; r = x % y;
      l = q[31:0]; h = r[31:0];
    end
  endfunction

  // Present one op in EX, hold it while stalled, check result in DONE.
  task automatic run_op(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    en = 1'b1; funct = v.f; operand_a = v.a; operand_b = v.b;
    #1;
    chk({tag, " busy@start"}, {63'd0, busy}, 64'd0);
    n = 0;
    while (stall_req && n < 100) begin
      n++;
      @(negedge clk); #1;
    end
    chk({tag, " stalls"}, 64'(n), 64'(v.stalls));
    chk({tag, " busy@done"}, {63'd0, busy}, 64'd1);
    chk({tag, " hi:lo"}, {hi, lo}, {v.hi, v.lo});
    @(negedge clk);
    en = 1'b0;
    #1;
    chk({tag, " idle after done"}, {62'd0, busy, stall_req}, 64'd0);
  endtask

  initial begin
    vec_t v;
    logic [31:0] eh, el, sh, sl;
    logic [5:0]  ops [4];
    ops[0] = FUNCT_MULT; ops[1] = FUNCT_MULTU; ops[2] = FUNCT_DIV; ops[3] = FUNCT_DIVU;

    // Directed table.
    tv.push_back('{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33});
    tv.push_back('{FUNCT_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33});
    tv.push_back('{FUNCT_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33});
    tv.push_back('{FUNCT_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33});
    tv.push_back('{FUNCT_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33});
    tv.push_back('{FUNCT_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 33});
    tv.push_back('{FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33});
    tv.push_back('{FUNCT_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1});
    tv.push_back('{FUNCT_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1});

    // Random ops against the model.
    for (int i = 0; i < 24; i++) begin
      v.f = ops[$urandom_range(0, 3)];
      v.a = $urandom;
      case ($urandom_range(0, 7))
        0:       v.b = 32'd0;
        1, 2:    v.b = $urandom_range(1, 15);
        3:       v.b = 32'hFFFFFFFF - $urandom_range(0, 3);
        default: v.b = $urandom;
      endcase
      model(v.f, v.a, v.b, eh, el);
      v.hi = eh; v.lo = el;
      v.stalls = ((v.f == FUNCT_DIV || v.f == FUNCT_DIVU) && v.b == 0) ? 1 : 33;
      tv.push_back(v);
    end

    // Reset: stall suppressed while rst high even with a mult presented.
    rst = 1'b1; en = 1'b1; flush = 1'b0; funct = FUNCT_MULT;
    operand_a = 32'd3; operand_b = 32'd4;
    #1;
    chk("reset stall", {63'd0, stall_req}, 64'd0);
    repeat (2) @(negedge clk);
    chk("reset hi:lo", {hi, lo}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    en = 1'b0; rst = 1'b0;

    foreach (tv[i]) run_op(tv[i], $sformatf("vec%0d", i));

    // Flush at iteration 10 of a MULT: no commit, back to IDLE.
    sh = hi; sl = lo;
    @(negedge clk);
    en = 1'b1; funct = FUNCT_MULT; operand_a = 32'h11111111; operand_b = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; en = 1'b0;
    #1;
    chk("flush busy/stall", {62'd0, busy, stall_req}, 64'd0);
    chk("flush hi:lo kept", {hi, lo}, {sh, sl});
    v = '{FUNCT_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 33};
    run_op(v, "post-flush multu");

    // Flush in the would-commit cycle suppresses the commit.
    sh = hi; sl = lo;
    @(negedge clk);
    en = 1'b1; funct = FUNCT_DIVU; operand_a = 32'd100; operand_b = 32'd7;
    repeat (32) @(negedge clk);
    #1;
    chk("last iter stall", {63'd0, stall_req}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; en = 1'b0;
    #1;
    chk("late flush hi:lo kept", {hi, lo}, {sh, sl});
    chk("late flush idle", {63'd0, busy}, 64'd0);

    // Reset mid-DIV is immediate, then MTHI with no stall.
    @(negedge clk);
    en = 1'b1; funct = FUNCT_DIV; operand_a = 32'd1000; operand_b = 32'd3;
    repeat (6) @(negedge clk);
    rst = 1'b1; en = 1'b0;
    #1;
    chk("async rst hi:lo", {hi, lo}, 64'd0);
    chk("async rst busy/stall", {62'd0, busy, stall_req}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    en = 1'b1; funct = FUNCT_MTHI; operand_a = 32'h1234;
    #1;
    chk("mthi stall", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    en = 1'b1; funct = FUNCT_MTLO; operand_a = 32'hABCD;
    #1;
    chk("mthi value", {32'd0, hi}, 64'h1234);
    @(negedge clk);
    en = 1'b1; funct = FUNCT_MULTU; operand_a = 32'd9; operand_b = 32'd9;
    flush = 1'b1;
    #1;
    chk("mtlo value", {32'd0, lo}, 64'hABCD);
    chk("flushed start no stall", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    flush = 1'b0; en = 1'b0;
    #1;
    chk("flushed start idle", {63'd0, busy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide controller for the EX stage. Owns the architectural HI/LO registers. Sequences iterative MULT/MULTU/DIV/DIVU operations selected by the SPECIAL `funct` code produced in ID. Holds the pipeline with a stall request until the result is committed, and services MTHI/MTLO writes and MFHI/MFLO reads.

## Interface
- No parameters; data width fixed at 32 bits.
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  EX-stage instruction valid (not a bubble).
- `flush`  in  1  synchronous cancel of the EX instruction.
- `funct`  in  6 (`FUNCT_BUS`)  ALU funct of the EX instruction.
- `operand_a`  in  32  rs value.
- `operand_b`  in  32  rt value.
- `stall_req`  out  1  hold IF/ID/EX; combinational.
- `hi`  out  32  HI register (MFHI source).
- `lo`  out  32  LO register (MFLO source).
- `busy`  out  1  state is not IDLE (registered).

## Operation
- States: IDLE, MUL, DIV, DONE.
- `start` = `en & ~flush & (state==IDLE) & funct ∈ {MULT, MULTU, DIV, DIVU}`.
- **IDLE + start, operand_b ≠ 0 or a multiply:**
  - Latch |a| and |b| (absolute values for signed ops; raw values for unsigned ops).
  - Latch sign flags `sa`, `sb` (forced to 0 for unsigned ops).
  - Clear the 5-bit `count`.
  - Go to MUL or DIV.
- **IDLE + start, DIV/DIVU with operand_b == 0:**
  - Go directly to DONE.
  - Commit `lo`=0xFFFFFFFF and `hi`=operand_a.
- **MUL:** one shift-add step per cycle into a 64-bit accumulator.
- **DIV:** one restoring-division step per cycle, producing a 32-bit quotient and a 32-bit remainder.
- **Leaving MUL/DIV:** when `count`==31, go to DONE and commit the result to `hi`/`lo` on the same edge.
- **Sign fix-up:**
  - Product is negated (64-bit two's complement) when `sa^sb`.
  - Quotient is negated when `sa^sb`.
  - Remainder is negated when `sa`.
  - 0x80000000 / 0xFFFFFFFF (signed) gives `lo`=0x80000000, `hi`=0 (the negation wraps).
- **DONE:** unconditionally go to IDLE. It never re-triggers, even though the same instruction is still presented in EX this cycle.
- **MTHI / MTLO in IDLE with `en & ~flush`:** write operand_a to `hi` / `lo` on the next edge. No stall.
- **MFHI / MFLO:** no action in this block; EX reads `hi`/`lo` directly.
- Any funct received while not IDLE is ignored.
- **`flush`:** from any state, go to IDLE on the next edge. Discard partial results; `hi`/`lo` are unchanged. A flush in the cycle MUL/DIV would commit suppresses that commit.
- **`stall_req`** = `start | (state==MUL) | (state==DIV)`, forced to 0 while `rst` is high.

## Timing
- **Reset values:** state IDLE, `hi`=0, `lo`=0, `busy`=0, `count`=0, `stall_req`=0.
- **Mult/div latency:**
  - Cycle 0 (IDLE, start): `stall_req`=1.
  - Cycles 1–32: iterate, `stall_req`=1.
  - End of cycle 32: `hi`/`lo` commit.
  - Cycle 33: DONE, `stall_req`=0, result visible; the instruction leaves EX at the end of cycle 33.
  - Total: 33 stall cycles.
- **Divide-by-zero:** 1 stall cycle (cycle 0). DONE in cycle 1 with the result visible.
- **MTHI/MTLO:** 0 stall cycles; the new value is visible the cycle after.
- **Reset mid-operation:** all state and outputs return to reset values immediately (asynchronously).
- **Back-to-back mult/div:** the next one can start in the cycle after DONE.

## Structure
- **`funct.v` constants:** `FUNCT_MFHI` 6'h10, `FUNCT_MTHI` 6'h11, `FUNCT_MFLO` 6'h12, `FUNCT_MTLO` 6'h13, `FUNCT_MULT` 6'h18, `FUNCT_MULTU` 6'h19, `FUNCT_DIV` 6'h1a, `FUNCT_DIVU` 6'h1b.
- **State encoding:** local `localparam`s, not shared.
- **Sub-module `muldiv_iter`:** holds the accumulator/remainder register and the one-step shift-add / shift-subtract datapath, with step and mode inputs. The FSM, sign handling and HI/LO stay in `muldiv_ctrl`.

## Test plan
- **MULTU, large operands:** 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. `stall_req` high for exactly 33 cycles; `busy` high cycles 1–33.
- **MULT, mixed signs:** −3 × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- **Signed and unsigned divide:**
  - DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU 7 / 2 → `lo`=3, `hi`=1.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Divide by zero:** DIVU 0x1234 / 0 → one stall cycle, then `lo`=0xFFFFFFFF, `hi`=0x1234.
- **Flush mid-MULT:** flush at iteration 10 → IDLE next cycle, `stall_req`=0, `hi`/`lo` unchanged. A following MULTU 5 × 6 gives `lo`=30.
- **Reset mid-DIV, then MTHI:** `rst` pulse mid-DIV → `hi`=`lo`=0 and `stall_req`=0 immediately. MTHI 0x1234 → `hi`=0x1234 the next cycle with no stall.
